// File: rtl/packet_queue.sv
// rtl/packet_queue.sv - packet-granular FIFO between UART receiver and sender
// Stores whole packets and launches them one at a time, paced by the sender busy flag.
module packet_queue #(
  parameter int PACKET_SIZE   = 4,
  parameter int DEPTH         = 4,
  parameter int ADDR_W        = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                     hwclk,
  input  logic                     rst_n,
  input  logic [8*PACKET_SIZE-1:0] in_packet,
  input  logic                     in_ready,
  output logic [8*PACKET_SIZE-1:0] out_packet,
  output logic                     out_enable,
  input  logic                     out_busy,
  output logic [ADDR_W:0]          count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int DW = 8 * PACKET_SIZE;
  localparam int TW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } state_e;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [DW-1:0]     mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [DW-1:0]     out_packet_q, out_packet_d;
  logic              out_enable_q, out_enable_d;
  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic pop;
  logic push;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    out_packet_d = out_packet_q;
    out_enable_d = 1'b0;
    state_d      = state_q;
    timer_d      = timer_q;

    pop  = (state_q == IDLE) && !empty_q && !out_busy;
    // A full queue still accepts when a slot frees up on the same edge.
    push = in_ready && (!full_q || pop);

    if (push) begin
      mem_d[wr_ptr_q] = in_packet;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (in_ready && !push) begin
      overflow_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (ADDR_W + 1)'(DEPTH));
    empty_d = (count_d == '0);

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          out_packet_d = mem_q[rd_ptr_q];
          rd_ptr_d     = rd_ptr_q + 1'b1;
          out_enable_d = 1'b1;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        // Exit on the cycle the timer would reach START_TIMEOUT-1, i.e. IDLE
        // is entered START_TIMEOUT cycles after LAUNCH.
        if (out_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 2)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!out_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      out_packet_q <= '0;
      out_enable_q <= 1'b0;
      state_q      <= IDLE;
      timer_q      <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      out_packet_q <= out_packet_d;
      out_enable_q <= out_enable_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
    end
  end

  assign out_packet = out_packet_q;
  assign out_enable = out_enable_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_packet_queue.sv
// tb/tb_packet_queue.sv - directed self-checking bench for packet_queue
// A negedge monitor records launches and models a sender that goes busy after each launch.
module tb_packet_queue;

  logic        hwclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_packet = '0;
  logic        in_ready = 1'b0;
  logic [31:0] out_packet;
  logic        out_enable;
  logic        out_busy;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  logic        force_busy = 1'b0;
  logic        model_en = 1'b0;
  logic        model_busy;
  int          bcnt = 0;
  logic        pend = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] launches[$];
  int          launch_cyc[$];
  int          cyc = 0;
  logic        prev_en = 1'b0;
  int          double_en = 0;

  assign model_busy = (bcnt != 0);
  assign out_busy   = force_busy | model_busy;

  packet_queue #(
    .PACKET_SIZE(4),
    .DEPTH(4),
    .ADDR_W(2),
    .START_TIMEOUT(8)
  ) dut (
    .hwclk(hwclk),
    .rst_n(rst_n),
    .in_packet(in_packet),
    .in_ready(in_ready),
    .out_packet(out_packet),
    .out_enable(out_enable),
    .out_busy(out_busy),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  always #5 hwclk = ~hwclk;

  // Sender model: busy rises one cycle after a launch and stays high for 10 cycles.
  always @(negedge hwclk) begin
    cyc++;
    if (out_enable === 1'b1) begin
      launches.push_back(out_packet);
      launch_cyc.push_back(cyc);
      if (prev_en) double_en++;
    end
    prev_en = (out_enable === 1'b1);
    if (bcnt != 0) bcnt--;
    if (pend) begin
      bcnt = 10;
      pend = 1'b0;
    end
    if (out_enable === 1'b1 && model_en) pend = 1'b1;
  end

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d);
    in_packet = d;
    in_ready  = 1'b1;
    tick();
    in_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_launches(input int n, input int budget);
    int k = 0;
    while (launches.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (launches.size() < n) begin
      errors++;
      $display("FAIL wait_launches: got %0d launches, expected %0d", launches.size(), n);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL reset_out_enable: got %b expected 0", out_enable); end
    checks++; if (out_packet !== 32'h0) begin errors++; $display("FAIL reset_out_packet: got %h expected 0", out_packet); end
    rst_n = 1'b1;
    force_busy = 1'b1;
    tick();
    strobe(32'h12345678);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty: got %b expected 1", empty); end
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL async_reset_out_enable: got %b expected 0", out_enable); end
    tick();
    rst_n = 1'b1;
    force_busy = 1'b0;
    tick();
  endtask

  task automatic test_single();
    launches.delete();
    launch_cyc.delete();
    strobe(32'hDEADBEEF);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", count); end
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL single_early_enable: got %b expected 0", out_enable); end
    tick();
    checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL single_enable: got %b expected 1", out_enable); end
    checks++; if (out_packet !== 32'hDEADBEEF) begin errors++; $display("FAIL single_packet: got %h expected deadbeef", out_packet); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
    tick();
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", out_enable); end
    checks++; if (out_packet !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got %h expected deadbeef", out_packet); end
    repeat (12) tick();
    checks++; if (launches.size() !== 1) begin errors++; $display("FAIL single_launches: got %0d expected 1", launches.size()); end
  endtask

  task automatic test_burst();
    launches.delete();
    launch_cyc.delete();
    double_en = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_packet = 32'h11111111 * (i + 1);
      in_ready  = 1'b1;
      tick();
    end
    in_ready = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL burst_count: got %0d expected 4", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL burst_full: got %b expected 1", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL burst_empty: got %b expected 0", empty); end
    checks++; if (launches.size() !== 0) begin errors++; $display("FAIL burst_no_launch: got %0d expected 0", launches.size()); end
    model_en = 1'b1;
    force_busy = 1'b0;
    wait_launches(4, 200);
    repeat (20) tick();
    checks++; if (launches.size() !== 4) begin errors++; $display("FAIL burst_launch_count: got %0d expected 4", launches.size()); end
    for (int i = 0; i < 4 && i < launches.size(); i++) begin
      logic [31:0] exp_v;
      exp_v = 32'h11111111 * (i + 1);
      checks++; if (launches[i] !== exp_v) begin errors++; $display("FAIL burst_order[%0d]: got %h expected %h", i, launches[i], exp_v); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL burst_drained: got %b expected 1", empty); end
    checks++; if (double_en !== 0) begin errors++; $display("FAIL burst_double_enable: got %0d expected 0", double_en); end
    model_en = 1'b0;
  endtask

  task automatic test_overflow();
    launches.delete();
    launch_cyc.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(32'h11111111 * (i + 1));
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    strobe(32'h55555555);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    repeat (3) tick();
    model_en = 1'b1;
    force_busy = 1'b0;
    wait_launches(4, 200);
    repeat (40) tick();
    checks++; if (launches.size() !== 4) begin errors++; $display("FAIL ovf_launch_count: got %0d expected 4", launches.size()); end
    for (int i = 0; i < 4 && i < launches.size(); i++) begin
      logic [31:0] exp_v;
      exp_v = 32'h11111111 * (i + 1);
      checks++; if (launches[i] !== exp_v) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, launches[i], exp_v); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", empty); end
    model_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_q[$];
    exp_q = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4, 32'h66666666};
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf_cleared: got %b expected 0", overflow); end
    launches.delete();
    launch_cyc.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(exp_q[i]);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_full: got %b expected 1", full); end
    in_packet  = 32'h66666666;
    in_ready   = 1'b1;
    force_busy = 1'b0;
    model_en   = 1'b1;
    tick();
    in_ready = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL sim_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_overflow: got %b expected 0", overflow); end
    checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL sim_enable: got %b expected 1", out_enable); end
    checks++; if (out_packet !== 32'hA1A1A1A1) begin errors++; $display("FAIL sim_first: got %h expected a1a1a1a1", out_packet); end
    wait_launches(5, 300);
    repeat (20) tick();
    checks++; if (launches.size() !== 5) begin errors++; $display("FAIL sim_launch_count: got %0d expected 5", launches.size()); end
    for (int i = 0; i < 5 && i < launches.size(); i++) begin
      checks++; if (launches[i] !== exp_q[i]) begin errors++; $display("FAIL sim_order[%0d]: got %h expected %h", i, launches[i], exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_drained: got %b expected 1", empty); end
    model_en = 1'b0;
  endtask

  task automatic test_timeout_reset();
    launches.delete();
    launch_cyc.delete();
    force_busy = 1'b1;
    strobe(32'hB1B1B1B1);
    strobe(32'hB2B2B2B2);
    force_busy = 1'b0;
    wait_launches(2, 100);
    if (launch_cyc.size() >= 2) begin
      checks++; if (launch_cyc[1] - launch_cyc[0] !== 9) begin errors++; $display("FAIL timeout_gap: got %0d cycles expected 9", launch_cyc[1] - launch_cyc[0]); end
      checks++; if (launches[0] !== 32'hB1B1B1B1 || launches[1] !== 32'hB2B2B2B2) begin errors++; $display("FAIL timeout_order: got %h %h expected b1b1b1b1 b2b2b2b2", launches[0], launches[1]); end
    end
    repeat (15) tick();
    launches.delete();
    launch_cyc.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(32'hC1C1C1C1 + i);
    force_busy = 1'b0;
    tick();
    checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL wd_launch: got %b expected 1", out_enable); end
    force_busy = 1'b1;
    tick();
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL wd_count: got %0d expected 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wd_reset_empty: got %b expected 1", empty); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wd_reset_count: got %0d expected 0", count); end
    tick();
    rst_n = 1'b1;
    force_busy = 1'b0;
    repeat (30) tick();
    checks++; if (launches.size() !== 1) begin errors++; $display("FAIL wd_no_relaunch: got %0d launches expected 1", launches.size()); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wd_stay_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
